imem_port_arbiter: RTL and testbench

//  Shares the single combinational read port of the byte-addressed instruction memory between
//  the core fetch unit (if_*) and the debug/loader read port (dbg_*).

---
 rtl/imem_port_arbiter.sv | 109 ++++++++++
 tb/tb_imem_port_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/imem_port_arbiter.sv
// Fetch/debug arbiter for the instruction memory read port, with registered responses.
// Optional address range checking is enabled by defining IMEM_ARB_RANGE_CHECK_EN.
module imem_port_arbiter #(
  parameter int MEM_BYTES = 1024,
  parameter int MAX_WAIT  = 4,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  output logic              if_err,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [31:0]       dbg_rdata,
  output logic              dbg_err,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata
);

  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);

  if (MEM_BYTES < 4 || MAX_WAIT < 1) begin : g_bad_cfg
    $error("imem_port_arbiter: MEM_BYTES must be >= 4 and MAX_WAIT >= 1");
  end

  logic [WCW-1:0]    wait_cnt_reg, wait_cnt_next;
  logic              dbg_win, if_win;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_bad;
  logic [31:0]       rdata_next;
  logic [1:0]        gnt_vec;

  // Grants are masked during reset so nothing is launched while rst is high.
  assign dbg_win = ~rst & dbg_req & (~if_req | (wait_cnt_reg == WAIT_MAX));
  assign if_win  = ~rst & if_req & ~dbg_win;
  assign dbg_gnt = dbg_win;
  assign if_gnt  = if_win;
  assign gnt_vec = {dbg_win, if_win};

  always_comb begin
    sel_addr = '0;
    if (dbg_win) begin
      sel_addr = dbg_addr;
    end else if (if_win) begin
      sel_addr = if_addr;
    end
  end

`ifdef IMEM_ARB_RANGE_CHECK_EN
  localparam logic [ADDR_W-1:0] TOP_ADDR = ADDR_W'(MEM_BYTES - 4);
  assign sel_bad = (sel_addr[1:0] != 2'b00) || (sel_addr > TOP_ADDR);
`else
  assign sel_bad = 1'b0;
`endif

  assign mem_addr   = sel_bad ? '0 : sel_addr;
  assign rdata_next = sel_bad ? 32'h0 : mem_rdata;

  always_comb begin
    wait_cnt_next = '0;
    if (dbg_req && !dbg_win) begin
      wait_cnt_next = (wait_cnt_reg == WAIT_MAX) ? WAIT_MAX : wait_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_reg <= '0;
    end else begin
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  // Index 0 is fetch, index 1 is debug; rdata/err only update on that side's grant.
  for (genvar gi = 0; gi < 2; gi++) begin : g_resp
    logic        rvalid_reg;
    logic        err_reg;
    logic [31:0] rdata_reg;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rvalid_reg <= 1'b0;
        err_reg    <= 1'b0;
        rdata_reg  <= 32'h0;
      end else begin
        rvalid_reg <= gnt_vec[gi];
        if (gnt_vec[gi]) begin
          err_reg   <= sel_bad;
          rdata_reg <= rdata_next;
        end
      end
    end
  end

  assign if_rvalid  = g_resp[0].rvalid_reg;
  assign if_rdata   = g_resp[0].rdata_reg;
  assign if_err     = g_resp[0].err_reg;
  assign dbg_rvalid = g_resp[1].rvalid_reg;
  assign dbg_rdata  = g_resp[1].rdata_reg;
  assign dbg_err    = g_resp[1].err_reg;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Randomized bench for imem_port_arbiter against a transaction-level reference model.
// Honours IMEM_ARB_RANGE_CHECK_EN when computing expected error/data/address.
module tb_imem_port_arbiter;

  localparam int MEM_BYTES = 1024;
  localparam int MAX_WAIT  = 4;
  localparam int ADDR_W    = 32;
  localparam int N_DIR     = 15;
  localparam int RST_K     = 13;
  localparam int N_CYC     = 400;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              if_req = 1'b0, dbg_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0, dbg_addr = '0;
  logic              if_gnt, if_rvalid, if_err, dbg_gnt, dbg_rvalid, dbg_err;
  logic [31:0]       if_rdata, dbg_rdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;

  logic [31:0] mem [256];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  imem_port_arbiter #(.MEM_BYTES(MEM_BYTES), .MAX_WAIT(MAX_WAIT), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
    .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  // Behavioural memory: out-of-range addresses return a recognisable pattern.
  assign mem_rdata = (mem_addr < MEM_BYTES) ? mem[mem_addr[9:2]] : (mem_addr ^ 32'hA5A5_5A5A);

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a < MEM_BYTES) ? mem[a[9:2]] : (a ^ 32'hA5A5_5A5A);
  endfunction

  function automatic logic addr_bad(input logic [31:0] a);
`ifdef IMEM_ARB_RANGE_CHECK_EN
    return (a % 4 != 0) || (a > MEM_BYTES - 4);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_data(input logic [31:0] a);
    return addr_bad(a) ? 32'h0 : mem_word(a);
  endfunction

  function automatic logic [31:0] rand_addr();
    int s;
    s = $urandom_range(0, 9);
    if (s <= 6) return {22'd0, 8'($urandom_range(0, 255)), 2'b00};
    else if (s == 7) return {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
    else if (s == 8) return 32'h3FC;
    else return 32'h400 + 32'($urandom_range(0, 64));
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // Directed prologue: starvation, fetch-only, debug-idle, range edges, reset mid-stream.
  logic        dir_if_req  [N_DIR] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1, 0, 1, 1, 1};
  logic [31:0] dir_if_addr [N_DIR] = '{32'h10, 32'h10, 32'h10, 32'h10, 32'h10, 32'h10, 32'h10,
                                       32'h0, 32'h0, 32'h400, 32'h4, 32'h0, 32'hC, 32'h20, 32'h24};
  logic        dir_dbg_req [N_DIR] = '{1, 1, 1, 1, 1, 0, 0, 1, 1, 0, 1, 1, 0, 0, 1};
  logic [31:0] dir_dbg_addr[N_DIR] = '{32'h3FC, 32'h3FC, 32'h3FC, 32'h3FC, 32'h3FC, 32'h0, 32'h0,
                                       32'h3FC, 32'h3FE, 32'h0, 32'h8, 32'h8, 32'h0, 32'h0, 32'h28};

  initial begin
    logic        exp_if_rv, exp_if_err, exp_dbg_rv, exp_dbg_err;
    logic [31:0] exp_if_rd, exp_dbg_rd, ga;
    logic        e_if, e_dbg, if_pend, dbg_pend;
    int          losses;

    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[4] = 32'h0050_0093;
    exp_if_rv = 0; exp_if_err = 0; exp_if_rd = 0;
    exp_dbg_rv = 0; exp_dbg_err = 0; exp_dbg_rd = 0;
    losses = 0; if_pend = 0; dbg_pend = 0;

    // Reset state with both requesters active.
    @(negedge clk);
    if_req = 1; if_addr = 32'h10; dbg_req = 1; dbg_addr = 32'h3FC;
    #1;
    check("rst_if_gnt", if_gnt, 0);
    check("rst_dbg_gnt", dbg_gnt, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_if_rvalid", if_rvalid, 0);
    check("rst_dbg_rvalid", dbg_rvalid, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_dbg_rdata", dbg_rdata, 0);
    check("rst_if_err", if_err, 0);
    check("rst_dbg_err", dbg_err, 0);
    @(posedge clk);
    #2 rst = 0;

    for (int k = 0; k < N_CYC; k++) begin
      @(negedge clk);
      check("if_rvalid", if_rvalid, exp_if_rv);
      check("if_rdata", if_rdata, exp_if_rd);
      if (exp_if_rv) check("if_err", if_err, exp_if_err);
      check("dbg_rvalid", dbg_rvalid, exp_dbg_rv);
      check("dbg_rdata", dbg_rdata, exp_dbg_rd);
      if (exp_dbg_rv) check("dbg_err", dbg_err, exp_dbg_err);

      if (k < N_DIR) begin
        if_req = dir_if_req[k];   if_addr = dir_if_addr[k];
        dbg_req = dir_dbg_req[k]; dbg_addr = dir_dbg_addr[k];
      end else begin
        // A losing request is usually held; occasionally it is abandoned.
        if (!(if_pend && $urandom_range(0, 9) != 0)) begin
          if_req = ($urandom_range(0, 9) < 6);
          if_addr = rand_addr();
        end
        if (!(dbg_pend && $urandom_range(0, 9) != 0)) begin
          dbg_req = ($urandom_range(0, 9) < 4);
          dbg_addr = rand_addr();
        end
      end
      #1;

      e_dbg = dbg_req && (!if_req || losses >= MAX_WAIT);
      e_if  = if_req && !e_dbg;
      check("if_gnt", if_gnt, e_if);
      check("dbg_gnt", dbg_gnt, e_dbg);
      if (k < 5) check("starve_gnt", dbg_gnt, (k == 4));
      ga = e_dbg ? dbg_addr : (e_if ? if_addr : 32'h0);
      check("mem_addr", mem_addr, addr_bad(ga) ? 32'h0 : ga);

      if (e_if) begin
        exp_if_rv = 1; exp_if_rd = exp_data(if_addr); exp_if_err = addr_bad(if_addr);
        $display("cyc %0d: fetch grant addr=0x%08h", k, if_addr);
      end else begin
        exp_if_rv = 0;
      end
      if (e_dbg) begin
        exp_dbg_rv = 1; exp_dbg_rd = exp_data(dbg_addr); exp_dbg_err = addr_bad(dbg_addr);
        $display("cyc %0d: debug grant addr=0x%08h after %0d losses", k, dbg_addr, losses);
      end else begin
        exp_dbg_rv = 0;
      end
      if (dbg_req && !e_dbg) losses = (losses < MAX_WAIT) ? losses + 1 : MAX_WAIT;
      else losses = 0;
      if_pend  = if_req && !e_if;
      dbg_pend = dbg_req && !e_dbg;

      if (k == RST_K) begin
        // Reset pulse spanning the edge that would have captured this grant.
        #1 rst = 1;
        #1;
        check("midrst_if_gnt", if_gnt, 0);
        check("midrst_dbg_gnt", dbg_gnt, 0);
        check("midrst_mem_addr", mem_addr, 0);
        exp_if_rv = 0; exp_if_rd = 0; exp_if_err = 0;
        exp_dbg_rv = 0; exp_dbg_rd = 0; exp_dbg_err = 0;
        losses = 0; if_pend = 0; dbg_pend = 0;
        #4 rst = 0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
